// File: rtl/mmx_operand_loader.sv
// Operand front-end for the mmx_chip multiplier: synchronises the strobe pin, collects an
// A/B operand pair one beat at a time and hands it to the core over valid/ready.
module mmx_operand_loader #(
    parameter int DW      = 7,
    parameter int TIMEOUT = 1023
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [DW-1:0] i_pin_data,
    input  logic          i_pin_stb,
    output logic [DW-1:0] o_op_a,
    output logic [DW-1:0] o_op_b,
    output logic          o_op_valid,
    input  logic          i_op_ready,
    output logic          o_busy,
    output logic          o_overrun,
    output logic          o_timeout
);

    localparam int CW = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_GOT_A,
        S_HOLD
    } state_t;

    state_t        r_state;
    logic          r_stb_s1;
    logic          r_stb_s2;
    logic          r_stb_s3;
    logic [DW-1:0] r_d_s1;
    logic [DW-1:0] r_d_s2;
    logic [1:0]    r_fill;
    logic          r_armed;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_op_a;
    logic [DW-1:0] r_op_b;
    logic          r_op_valid;
    logic          r_busy;
    logic          r_overrun;
    logic          r_timeout;

    state_t        w_state_next;
    logic [CW-1:0] w_cnt_next;
    logic [DW-1:0] w_op_a_next;
    logic [DW-1:0] w_op_b_next;
    logic          w_op_valid_next;
    logic          w_overrun_next;
    logic          w_timeout_next;
    logic          w_edge;
    logic          w_handshake;

    // The synchroniser stages hold reset values for two cycles after release, so arming
    // waits until stb_s2 carries a genuine pin sample; a strobe held across reset is ignored.
    assign w_edge      = r_stb_s2 & ~r_stb_s3 & r_armed;
    assign w_handshake = (r_state == S_HOLD) & r_op_valid & i_op_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= S_IDLE;
            r_stb_s1   <= 1'b0;
            r_stb_s2   <= 1'b0;
            r_stb_s3   <= 1'b0;
            r_d_s1     <= '0;
            r_d_s2     <= '0;
            r_fill     <= 2'b00;
            r_armed    <= 1'b0;
            r_cnt      <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_stb_s1   <= i_pin_stb;
            r_stb_s2   <= r_stb_s1;
            r_stb_s3   <= r_stb_s2;
            r_d_s1     <= i_pin_data;
            r_d_s2     <= r_d_s1;
            r_fill     <= {r_fill[0], 1'b1};
            if (r_fill[1] && !r_stb_s2) begin
                r_armed <= 1'b1;
            end
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_op_a     <= w_op_a_next;
            r_op_b     <= w_op_b_next;
            r_op_valid <= w_op_valid_next;
            r_busy     <= (w_state_next != S_IDLE);
            r_overrun  <= w_overrun_next;
            r_timeout  <= w_timeout_next;
        end
    end

    // A beat arriving with the handshake starts the next pair instead of counting as overrun.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_op_a_next     = r_op_a;
        w_op_b_next     = r_op_b;
        w_op_valid_next = r_op_valid;
        w_overrun_next  = r_overrun;
        w_timeout_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_edge) begin
                    w_op_a_next  = r_d_s2;
                    w_cnt_next   = '0;
                    w_state_next = S_GOT_A;
                end
            end
            S_GOT_A: begin
                if (w_edge) begin
                    w_op_b_next     = r_d_s2;
                    w_op_valid_next = 1'b1;
                    w_state_next    = S_HOLD;
                end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
                    w_timeout_next = 1'b1;
                    w_state_next   = S_IDLE;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (w_handshake) begin
                    w_op_valid_next = 1'b0;
                    if (w_edge) begin
                        w_op_a_next  = r_d_s2;
                        w_cnt_next   = '0;
                        w_state_next = S_GOT_A;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else if (w_edge) begin
                    w_overrun_next = 1'b1;
                end
            end
            default: begin
                w_state_next    = S_IDLE;
                w_op_valid_next = 1'b0;
            end
        endcase
    end

    assign o_op_a     = r_op_a;
    assign o_op_b     = r_op_b;
    assign o_op_valid = r_op_valid;
    assign o_busy     = r_busy;
    assign o_overrun  = r_overrun;
    assign o_timeout  = r_timeout;

endmodule
